// File: rtl/spi_csr_pkg.sv
// ============================================================================
// spi_csr_pkg : register map and STATUS layout for spi_csr_bridge (rev 1.0)
// ============================================================================
`default_nettype none

package spi_csr_pkg;

  // Register indices (bus_addr[3:2])
  localparam logic [1:0] RXDATA_OFS = 2'd0;
  localparam logic [1:0] TXDATA_OFS = 2'd1;
  localparam logic [1:0] STATUS_OFS = 2'd2;
  localparam logic [1:0] CTRL_OFS   = 2'd3;

  localparam int ST_NONEMPTY_BIT = 0;
  localparam int ST_FULL_BIT     = 1;
  localparam int ST_OVERFLOW_BIT = 2;
  localparam int ST_MODE_BIT     = 3;
  localparam int ST_CMD_ERR_BIT  = 4;
  localparam int ST_COUNT_LSB    = 8;
  localparam int CTRL_IRQ_EN_BIT = 0;

  // Low byte of STATUS; rx_count is appended above it by the bridge
  typedef struct packed {
    logic [2:0] rsvd;
    logic       cmd_error;
    logic       mode;
    logic       rx_overflow;
    logic       rx_full;
    logic       rx_nonempty;
  } status_t;

endpackage

`default_nettype wire

// File: rtl/spi_csr_bridge_byte_fifo.sv
// ============================================================================
// byte_fifo : circular byte FIFO with synchronous flush (rev 1.0)
// ============================================================================
`default_nettype none

module byte_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign count = cnt_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    // A push into a full FIFO is accepted only when a pop frees the slot
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_csr_bridge.sv
// ============================================================================
// spi_csr_bridge : 4-word CSR window between the SPI wrapper and the CPU bus (rev 1.0)
// ============================================================================
`default_nettype none

module spi_csr_bridge
  import spi_csr_pkg::*;
#(
  parameter  int RX_DEPTH = 4,
  localparam int CNT_W    = $clog2(RX_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_buff,
  input  logic        rx_valid,
  input  logic        mode,
  input  logic        cmd_error,
  output logic [7:0]  tx_buff,
  output logic        tx_valid,
  input  logic [3:0]  bus_addr,
  input  logic        bus_rd_en,
  input  logic        bus_wr_en,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rdata_valid,
  output logic        irq
);

  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic             flush, push, pop, rd, wr;
  logic [1:0]       sel;
  status_t          status;
  logic [31:0]      rdata_w;

  logic             mode_q, mode_d;
  logic             overflow_q, overflow_d;
  logic             irq_en_q, irq_en_d;
  logic [7:0]       tx_buff_q, tx_buff_d;
  logic             tx_valid_q, tx_valid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rdata_valid_q, rdata_valid_d;
  logic             irq_q, irq_d;

  logic             unused_ok;
  assign unused_ok = ^{bus_addr[1:0], bus_wdata[31:8]};

  assign sel   = bus_addr[3:2];
  assign wr    = bus_wr_en;
  assign rd    = bus_rd_en & ~bus_wr_en;
  assign flush = mode_q & ~mode;
  assign push  = rx_valid & ~flush;
  assign pop   = rd & (sel == RXDATA_OFS) & ~fifo_empty;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (rx_buff),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status             = '0;
    status.rx_nonempty = ~fifo_empty;
    status.rx_full     = fifo_full;
    status.rx_overflow = overflow_q;
    status.mode        = mode;
    status.cmd_error   = cmd_error;

    rdata_w = '0;
    case (sel)
      RXDATA_OFS: if (!fifo_empty) rdata_w = {23'd0, 1'b1, fifo_dout};
      TXDATA_OFS: rdata_w = {24'd0, tx_buff_q};
      STATUS_OFS: rdata_w = 32'(status) | (32'(fifo_count) << ST_COUNT_LSB);
      default:    rdata_w = {31'd0, irq_en_q};
    endcase
  end

  always_comb begin
    mode_d        = mode;
    overflow_d    = overflow_q;
    irq_en_d      = irq_en_q;
    tx_buff_d     = tx_buff_q;
    tx_valid_d    = 1'b0;
    rdata_d       = rd ? rdata_w : rdata_q;
    rdata_valid_d = rd;
    irq_d         = irq_en_q & (~fifo_empty | overflow_q);

    if (wr && sel == STATUS_OFS && bus_wdata[ST_OVERFLOW_BIT]) overflow_d = 1'b0;
    // Set beats W1C; a simultaneous pop makes room so no byte is lost
    if (push && fifo_full && !pop) overflow_d = 1'b1;
    if (wr && sel == CTRL_OFS) irq_en_d = bus_wdata[CTRL_IRQ_EN_BIT];
    if (wr && sel == TXDATA_OFS) begin
      tx_buff_d  = bus_wdata[7:0];
      tx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q        <= 1'b0;
      overflow_q    <= 1'b0;
      irq_en_q      <= 1'b0;
      tx_buff_q     <= '0;
      tx_valid_q    <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      overflow_q    <= overflow_d;
      irq_en_q      <= irq_en_d;
      tx_buff_q     <= tx_buff_d;
      tx_valid_q    <= tx_valid_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      irq_q         <= irq_d;
    end
  end

  assign tx_buff         = tx_buff_q;
  assign tx_valid        = tx_valid_q;
  assign bus_rdata       = rdata_q;
  assign bus_rdata_valid = rdata_valid_q;
  assign irq             = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_csr_bridge.sv
// ============================================================================
// tb_spi_csr_bridge : directed self-checking bench for spi_csr_bridge (rev 1.0)
// ============================================================================
`default_nettype none

module tb_spi_csr_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_buff = '0;
  logic        rx_valid = 1'b0;
  logic        mode = 1'b1;
  logic        cmd_error = 1'b1;
  logic [7:0]  tx_buff;
  logic        tx_valid;
  logic [3:0]  bus_addr = '0;
  logic        bus_rd_en = 1'b0;
  logic        bus_wr_en = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_rdata_valid;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rdat;

  localparam logic [3:0] A_RX = 4'h0, A_TX = 4'h4, A_ST = 4'h8, A_CT = 4'hC;

  spi_csr_bridge #(.RX_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_buff(rx_buff), .rx_valid(rx_valid),
    .mode(mode), .cmd_error(cmd_error), .tx_buff(tx_buff), .tx_valid(tx_valid),
    .bus_addr(bus_addr), .bus_rd_en(bus_rd_en), .bus_wr_en(bus_wr_en),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_rdata_valid(bus_rdata_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge
  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus_addr  = a;
    bus_rd_en = 1'b1;
    @(negedge clk);
    bus_rd_en = 1'b0;
    check("rdata_valid", {31'd0, bus_rdata_valid}, 32'd1);
    d = bus_rdata;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr_en = 1'b1;
    @(negedge clk);
    bus_wr_en = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    rx_buff  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset state
    @(negedge clk);
    check("rst_rdata", bus_rdata, 32'h0);
    check("rst_rvalid", {31'd0, bus_rdata_valid}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_txv", {31'd0, tx_valid}, 32'h0);
    check("rst_txb", {24'd0, tx_buff}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(A_ST, rdat); check("st_reset", rdat, 32'h18);

    // 2. two bytes in, drained, then empty read
    push(8'hA5); push(8'h3C);
    bus_read(A_RX, rdat); check("rx_a5", rdat, 32'h1A5);
    bus_read(A_RX, rdat); check("rx_3c", rdat, 32'h13C);
    bus_read(A_RX, rdat); check("rx_empty", rdat, 32'h0);
    bus_read(A_ST, rdat); check("st_empty", rdat, 32'h18);

    // 3. overflow with five pushes into depth 4
    for (int i = 1; i <= 5; i++) push(8'(i));
    bus_read(A_ST, rdat); check("st_ovf", rdat, 32'h41F);
    for (int i = 1; i <= 4; i++) begin
      bus_read(A_RX, rdat); check("rx_ovf_drain", rdat, 32'h100 + 32'(i));
    end
    bus_read(A_ST, rdat); check("st_ovf_sticky", rdat, 32'h1C);
    bus_write(A_ST, 32'h4);
    bus_read(A_ST, rdat); check("st_w1c", rdat, 32'h18);

    // 4. full FIFO, push and pop in the same cycle
    for (int i = 1; i <= 4; i++) push(8'h10 + 8'(i));
    rx_buff = 8'h77; rx_valid = 1'b1;
    bus_read(A_RX, rdat);
    rx_valid = 1'b0;
    check("rx_full_pp", rdat, 32'h111);
    bus_read(A_ST, rdat); check("st_full_pp", rdat, 32'h41B);
    for (int i = 2; i <= 4; i++) begin
      bus_read(A_RX, rdat); check("rx_pp_drain", rdat, 32'h110 + 32'(i));
    end
    bus_read(A_RX, rdat); check("rx_pp_last", rdat, 32'h177);

    // 5. transmit path
    bus_write(A_TX, 32'hFFFF_FF5A);
    check("txv_pulse", {31'd0, tx_valid}, 32'd1);
    check("txb_5a", {24'd0, tx_buff}, 32'h5A);
    @(negedge clk);
    check("txv_low", {31'd0, tx_valid}, 32'd0);
    bus_read(A_TX, rdat); check("rd_tx", rdat, 32'h5A);
    bus_write(A_TX, 32'h11);
    bus_write(A_TX, 32'h22);
    check("txv_b2b", {31'd0, tx_valid}, 32'd1);
    check("txb_b2b", {24'd0, tx_buff}, 32'h22);
    // simultaneous read and write: write wins, read dropped
    bus_addr = A_TX; bus_wdata = 32'h33; bus_wr_en = 1'b1; bus_rd_en = 1'b1;
    @(negedge clk);
    bus_wr_en = 1'b0; bus_rd_en = 1'b0;
    check("rw_no_rvalid", {31'd0, bus_rdata_valid}, 32'd0);
    check("rw_txb", {24'd0, tx_buff}, 32'h33);

    // 6. interrupt and mode flush
    bus_write(A_CT, 32'hFFFF_FFFF);
    bus_read(A_CT, rdat); check("rd_ctrl", rdat, 32'h1);
    check("irq_idle", {31'd0, irq}, 32'd0);
    push(8'hAB);
    check("irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_set", {31'd0, irq}, 32'd1);
    push(8'hAC);
    mode = 1'b0; rx_buff = 8'hCD; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check("irq_flush", {31'd0, irq}, 32'd0);
    bus_read(A_ST, rdat); check("st_flush", rdat, 32'h10);
    bus_read(A_RX, rdat); check("rx_flush", rdat, 32'h0);

    // mid-operation reset
    push(8'h55);
    bus_write(A_TX, 32'h99);
    rst_n = 1'b0;
    #1;
    check("mrst_txv", {31'd0, tx_valid}, 32'd0);
    check("mrst_txb", {24'd0, tx_buff}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(A_ST, rdat); check("mrst_st", rdat, 32'h10);
    bus_read(A_CT, rdat); check("mrst_ctrl", rdat, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
